// File: rtl/tx_frame_scheduler_pkg.sv
// Shared constants for the UART frame scheduler: FSM encoding, header sync
// nibble and the native sample width.
package tx_frame_scheduler_pkg;

    localparam int SAMPLE_W = 40;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    function automatic logic [7:0] header_byte(input logic [3:0] sync, input logic [3:0] ch);
        return {sync, ch};
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester after ptr (wrapping)
// wins; produces a one-hot grant and the matching binary index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler sharing one byte-serial UART transmitter
// between NUM_CH sample producers: header {SYNC, ch} then payload LSB first.
//
// state | meaning
// IDLE  | no frame; grant the next requester (round-robin after ptr)
// START | byte loaded in tx_byte; tx_start pulses on the following cycle
// WAIT  | transmitter busy with tx_byte; tx_done loads next byte or ends frame
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int         NUM_CH     = 4,
    parameter int         DATA_BYTES = SAMPLE_W / 8,
    parameter logic [3:0] SYNC       = SYNC_NIBBLE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req,
    input  logic [NUM_CH*8*DATA_BYTES-1:0] data_in,
    output logic [NUM_CH-1:0]              ack,
    output logic [7:0]                     tx_byte,
    output logic                           tx_start,
    input  logic                           tx_done,
    output logic                           busy,
    output logic [3:0]                     cur_ch,
    output logic                           frame_done
);

    localparam int SW    = 8 * DATA_BYTES;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BI_W  = $clog2(DATA_BYTES + 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic [3:0]        cur_ch_q, cur_ch_d;
    logic              frame_done_q, frame_done_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;

    rr_arbiter #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        ack_d        = '0;
        tx_byte_d    = tx_byte_q;
        busy_d       = busy_q;
        cur_ch_d     = cur_ch_q;
        frame_done_d = 1'b0;
        // registered decode keeps tx_start one cycle behind the START state
        tx_start_d   = (state_q == ST_START);

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    ack_d      = arb_grant;
                    ptr_d      = arb_idx;
                    cur_ch_d   = 4'(arb_idx);
                    busy_d     = 1'b1;
                    tx_byte_d  = header_byte(SYNC, 4'(arb_idx));
                    shift_d    = data_in[int'(arb_idx) * SW +: SW];
                    byte_idx_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q < BI_W'(DATA_BYTES)) begin
                        tx_byte_d  = shift_q[7:0];
                        shift_d    = shift_q >> 8;
                        byte_idx_d = byte_idx_q + BI_W'(1);
                        state_d    = ST_START;
                    end else begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // pointer resets to the last channel so channel 0 is granted first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IDX_W'(NUM_CH - 1);
            shift_q      <= '0;
            byte_idx_q   <= '0;
            ack_q        <= '0;
            tx_byte_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            cur_ch_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            ack_q        <= ack_d;
            tx_byte_q    <= tx_byte_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            cur_ch_q     <= cur_ch_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ack        = ack_q;
    assign tx_byte    = tx_byte_q;
    assign tx_start   = tx_start_q;
    assign busy       = busy_q;
    assign cur_ch     = cur_ch_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: vector table, directed corner
// sequences and a randomized run against a frame-level reference model.
module tb_tx_frame_scheduler;

    localparam int NUM_CH     = 4;
    localparam int DATA_BYTES = 5;

    typedef struct {
        logic [3:0]  req;
        logic [39:0] sample;
        int          dly;
        logic [3:0]  exp_ack;
        logic [47:0] exp_frame;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [159:0] data_in = '0;
    logic [3:0]   ack;
    logic [7:0]   tx_byte;
    logic         tx_start;
    logic         tx_done;
    logic         resp_done = 1'b0;
    logic         man_done = 1'b0;
    logic         busy;
    logic [3:0]   cur_ch;
    logic         frame_done;

    int   errors = 0;
    int   checks = 0;
    int   resp_dly = 2;
    logic auto_en = 1'b1;
    logic [7:0] obs_bytes[$];

    assign tx_done = resp_done | man_done;

    always #5 clk = ~clk;

    tx_frame_scheduler #(
        .NUM_CH     (NUM_CH),
        .DATA_BYTES (DATA_BYTES),
        .SYNC       (4'hA)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .cur_ch     (cur_ch),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // transmitter model: tx_done resp_dly cycles after each tx_start
    initial begin
        forever begin
            @(negedge clk);
            while (auto_en && tx_start) begin
                repeat (resp_dly) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    // byte capture plus single-cycle / one-hot pulse checks
    initial begin
        logic [3:0] prev_ack;
        logic       prev_start;
        prev_ack   = '0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ack   = '0;
                prev_start = 1'b0;
            end else begin
                if (tx_start) begin
                    obs_bytes.push_back(tx_byte);
                    checks++;
                    if (prev_start) begin
                        errors++;
                        $display("FAIL start_pulse: tx_start high 2 cycles, required 1");
                    end
                end
                if (ack != '0) begin
                    checks++;
                    if ($countones(ack) != 1 || prev_ack != '0) begin
                        errors++;
                        $display("FAIL ack_pulse: got %b after %b, required one-hot single cycle", ack, prev_ack);
                    end
                end
                prev_ack   = ack;
                prev_start = tx_start;
            end
        end
    end

    task automatic wait_ack(output logic [3:0] a, output int gap, output logic ok);
        ok  = 1'b0;
        a   = '0;
        gap = 0;
        while (!ok && gap < 200) begin
            if (ack != '0) begin
                a  = ack;
                ok = 1'b1;
            end else begin
                @(negedge clk);
                gap++;
            end
        end
        if (!ok) fail_timeout("ack_wait");
    endtask

    task automatic wait_done(output logic ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 500) begin
            if (frame_done) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ok) fail_timeout("frame_done_wait");
    endtask

    task automatic wait_start(output logic ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            if (tx_start) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ok) fail_timeout("tx_start_wait");
    endtask

    task automatic finish_frame(input string name, input logic [47:0] exp_frame);
        logic        ok;
        logic [47:0] got;
        wait_done(ok);
        if (ok) begin
            chk({name, ".busy_end"}, 64'(busy), 64'(0));
            chk({name, ".nbytes"}, 64'(obs_bytes.size()), 64'(DATA_BYTES + 1));
            got = '0;
            foreach (obs_bytes[i]) got = {got[39:0], obs_bytes[i]};
            chk({name, ".frame"}, 64'(got), 64'(exp_frame));
        end
    endtask

    task automatic run_frame(input string name, input logic [3:0] exp_ack, input logic [47:0] exp_frame,
                             input logic [3:0] req_after, input logic scramble, output int gap);
        logic [3:0] a;
        logic       ok;
        obs_bytes.delete();
        wait_ack(a, gap, ok);
        if (ok) begin
            chk({name, ".ack"}, 64'(a), 64'(exp_ack));
            chk({name, ".busy"}, 64'(busy), 64'(1));
            chk({name, ".cur_ch"}, 64'(cur_ch), 64'(exp_frame[43:40]));
            chk({name, ".start_early"}, 64'(tx_start), 64'(0));
            req = req_after;
            if (scramble) data_in = ~data_in;
            @(negedge clk);
            chk({name, ".start_lat"}, 64'(tx_start), 64'(1));
            chk({name, ".hdr"}, 64'(tx_byte), 64'(exp_frame[47:40]));
            finish_frame(name, exp_frame);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req      = '0;
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // reference: first requester strictly after the last grant, wrapping
    function automatic int rr_expect(input logic [3:0] m, input int last);
        for (int k = 1; k <= NUM_CH; k++)
            if (m[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        return -1;
    endfunction

    function automatic logic [47:0] make_frame(input int ch, input logic [39:0] s);
        logic [47:0] f;
        f = 48'({4'hA, 4'(ch)});
        for (int j = 0; j < DATA_BYTES; j++) f = {f[39:0], s[8*j +: 8]};
        return f;
    endfunction

    initial begin
        vec_t        vecs[8];
        int          gap;
        logic [3:0]  a;
        logic        ok;
        logic [3:0]  mask;
        logic [39:0] s;
        int          last;
        int          ch;

        vecs[0] = '{4'b0100, 40'h1122334455, 2, 4'b0100, 48'hA2_5544332211};
        vecs[1] = '{4'b0001, 40'hCAFEBABE01, 1, 4'b0001, 48'hA0_01BEBAFECA};
        vecs[2] = '{4'b1000, 40'h0000000000, 3, 4'b1000, 48'hA3_0000000000};
        vecs[3] = '{4'b0010, 40'hFFEEDDCCBB, 2, 4'b0010, 48'hA1_BBCCDDEEFF};
        vecs[4] = '{4'b1111, 40'h0102030405, 1, 4'b0100, 48'hA2_0504030201};
        vecs[5] = '{4'b1001, 40'h8877665544, 2, 4'b1000, 48'hA3_4455667788};
        vecs[6] = '{4'b0011, 40'h13579BDF02, 3, 4'b0001, 48'hA0_02DF9B5713};
        vecs[7] = '{4'b0110, 40'h00000000FF, 1, 4'b0010, 48'hA1_FF00000000};

        repeat (3) @(negedge clk);
        chk("reset.ack", 64'(ack), 64'(0));
        chk("reset.tx_byte", 64'(tx_byte), 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.tx_start", 64'(tx_start), 64'(0));
        chk("reset.cur_ch", 64'(cur_ch), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            req      = vecs[i].req;
            data_in  = {4{vecs[i].sample}};
            resp_dly = vecs[i].dly;
            run_frame($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_frame, 4'b0000, 1'b1, gap);
        end

        // contention with all requests held: 0,1,2,3,0
        do_reset();
        resp_dly = 2;
        req      = 4'b1111;
        data_in  = {4{40'hAABBCCDDEE}};
        for (int k = 0; k < 5; k++) begin
            run_frame($sformatf("cont%0d", k), 4'(1 << (k % 4)), {4'hA, 4'(k % 4), 40'hEEDDCCBBAA},
                      (k == 4) ? 4'b0000 : 4'b1111, 1'b0, gap);
            if (k > 0) chk($sformatf("cont%0d.gap", k), 64'(gap), 64'(1));
        end

        // data isolation after grant
        do_reset();
        obs_bytes.delete();
        data_in = {4{40'h0102030405}};
        req     = 4'b0001;
        wait_ack(a, gap, ok);
        chk("iso1.ack", 64'(a), 64'(4'b0001));
        req = '0;
        @(negedge clk);
        data_in[39:0] = 40'h123456789A;
        finish_frame("iso1", 48'hA0_0504030201);
        req = 4'b0001;
        run_frame("iso2", 4'b0001, 48'hA0_9A78563412, 4'b0000, 1'b0, gap);

        // spurious tx_done in IDLE and in START cycles
        do_reset();
        auto_en  = 1'b0;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        chk("spur_idle.busy", 64'(busy), 64'(0));
        chk("spur_idle.tx_byte", 64'(tx_byte), 64'(0));
        chk("spur_idle.tx_start", 64'(tx_start), 64'(0));
        obs_bytes.delete();
        data_in = {4{40'h1122334455}};
        req     = 4'b0100;
        wait_ack(a, gap, ok);
        chk("spur.ack", 64'(a), 64'(4'b0100));
        man_done = 1'b1;
        req      = '0;
        @(negedge clk);
        man_done = 1'b0;
        chk("spur_start.tx_start", 64'(tx_start), 64'(1));
        chk("spur_start.tx_byte", 64'(tx_byte), 64'(8'hA2));
        for (int b = 0; b <= DATA_BYTES; b++) begin
            if (b > 0) wait_start(ok);
            repeat (2) @(negedge clk);
            man_done = 1'b1;
            @(negedge clk);
            if (b == 2) begin
                @(negedge clk);
                chk("spur_hold.tx_byte", 64'(tx_byte), 64'(8'h33));
            end
            man_done = 1'b0;
        end
        finish_frame("spur", 48'hA2_5544332211);
        auto_en = 1'b1;

        // reset in the middle of a frame
        do_reset();
        resp_dly = 2;
        obs_bytes.delete();
        data_in = {4{40'h0A0B0C0D0E}};
        req     = 4'b0010;
        wait_ack(a, gap, ok);
        chk("rst_mid.ack", 64'(a), 64'(4'b0010));
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (obs_bytes.size() >= 3) ok = 1'b1;
        end
        if (!ok) fail_timeout("rst_mid.bytes");
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ack0", 64'(ack), 64'(0));
        chk("rst_mid.tx_byte0", 64'(tx_byte), 64'(0));
        chk("rst_mid.tx_start0", 64'(tx_start), 64'(0));
        chk("rst_mid.busy0", 64'(busy), 64'(0));
        chk("rst_mid.cur_ch0", 64'(cur_ch), 64'(0));
        chk("rst_mid.frame_done0", 64'(frame_done), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_frame("rst_recover", 4'b0010, 48'hA1_0E0D0C0B0A, 4'b0000, 1'b0, gap);

        // back-to-back frames from one held request
        do_reset();
        resp_dly = 1;
        data_in  = {4{40'h5A5A5A5A5A}};
        req      = 4'b1000;
        for (int f = 0; f < 3; f++) begin
            run_frame($sformatf("b2b%0d", f), 4'b1000, 48'hA3_5A5A5A5A5A,
                      (f == 2) ? 4'b0000 : 4'b1000, 1'b0, gap);
            if (f > 0) chk($sformatf("b2b%0d.gap", f), 64'(gap), 64'(1));
        end

        // randomized requests against the reference model
        do_reset();
        last = NUM_CH - 1;
        mask = '0;
        for (int it = 0; it < 30; it++) begin
            mask = mask | 4'($urandom_range(0, 15));
            if (mask == '0) mask = 4'(1 << $urandom_range(0, 3));
            for (int c = 0; c < NUM_CH; c++) begin
                s = 40'({$urandom(), $urandom()});
                data_in[c*40 +: 40] = s;
            end
            resp_dly = int'($urandom_range(1, 3));
            ch   = rr_expect(mask, last);
            last = ch;
            s    = data_in[ch*40 +: 40];
            req  = mask;
            mask = mask & ~4'(1 << ch);
            run_frame($sformatf("rand%0d", it), 4'(1 << ch), make_frame(ch, s), mask, 1'b1, gap);
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
